// File: rtl/cms_trace_packer.sv
// Trace front-end: captures retired pc/instr with per-event delta counts, filters by pc range,
// buffers items in a FIFO and streams them as AXI-Stream beats with programmable packet length.
module cms_trace_packer #(
  parameter int XLEN                                = 64,
  parameter int NUM_EVENTS                          = 8,
  parameter int COUNTER_WIDTH                       = 16,
  parameter int AXI_DATA_WIDTH                      = 512,
  parameter int FIFO_DEPTH                          = 16,
  parameter int CTRL_ADDR_WIDTH                     = 8,
  parameter int CTRL_DATA_WIDTH                     = 64,
  parameter int CTRL_WRITE_ENABLE_POSEDGE_TRIGGERED = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [31:0]                instr,
  input  logic [XLEN-1:0]            pc,
  input  logic                       pc_valid,
  input  logic [NUM_EVENTS-1:0]      performance_events,
  input  logic                       en,
  input  logic [CTRL_ADDR_WIDTH-1:0] ctrl_addr,
  input  logic [CTRL_DATA_WIDTH-1:0] ctrl_wdata,
  input  logic                       ctrl_write_enable,
  input  logic [31:0]                tlast_interval,
  output logic                       M_AXIS_tvalid,
  input  logic                       M_AXIS_tready,
  output logic [AXI_DATA_WIDTH-1:0]  M_AXIS_tdata,
  output logic                       M_AXIS_tlast,
  output logic [31:0]                drop_count
);
  localparam int ITEM_W = XLEN + 32 + NUM_EVENTS * COUNTER_WIDTH;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  logic                     we_q, en_q, wr_act, flush;
  logic                     trace_en, filter_en;
  logic [XLEN-1:0]          range_lo, range_hi;
  logic                     capture, full, pop, push_ok, drop, drain;
  logic [COUNTER_WIDTH-1:0] ctr     [NUM_EVENTS];
  logic [COUNTER_WIDTH-1:0] ctr_inc [NUM_EVENTS];
  logic [ITEM_W-1:0]        item;
  logic [ITEM_W-1:0]        mem     [FIFO_DEPTH];
  logic [PTR_W-1:0]         wr_ptr, rd_ptr;
  logic [CNT_W-1:0]         count, count_next;
  logic [31:0]              beat_cnt, last_idx;

  always_comb begin
    if (CTRL_WRITE_ENABLE_POSEDGE_TRIGGERED != 0) wr_act = ctrl_write_enable & ~we_q;
    else                                          wr_act = ctrl_write_enable;
  end
  assign flush = wr_act && (ctrl_addr == CTRL_ADDR_WIDTH'(3));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q      <= 1'b0;
      en_q      <= 1'b0;
      trace_en  <= 1'b0;
      filter_en <= 1'b0;
      range_lo  <= '0;
      range_hi  <= '1;
    end else begin
      we_q <= ctrl_write_enable;
      en_q <= en;
      if (wr_act) begin
        case (ctrl_addr)
          CTRL_ADDR_WIDTH'(0): begin
            trace_en  <= ctrl_wdata[0];
            filter_en <= ctrl_wdata[1];
          end
          CTRL_ADDR_WIDTH'(1): range_lo <= ctrl_wdata[XLEN-1:0];
          CTRL_ADDR_WIDTH'(2): range_hi <= ctrl_wdata[XLEN-1:0];
          default: ;
        endcase
      end
    end
  end

  assign capture = en & trace_en & pc_valid & (~filter_en | ((pc >= range_lo) & (pc <= range_hi)));
  assign full    = (count == CNT_W'(FIFO_DEPTH));
  assign pop     = M_AXIS_tvalid & M_AXIS_tready;
  assign push_ok = capture & (~full | pop);
  assign drop    = capture & full & ~pop;

  // NOTE: every variable driven here gets a default first, so no latch can be inferred.
  always_comb begin
    item                = '0;
    item[XLEN-1:0]      = pc;
    item[XLEN +: 32]    = instr;
    for (int i = 0; i < NUM_EVENTS; i++) begin
      ctr_inc[i] = (performance_events[i] && ctr[i] != '1) ? ctr[i] + 1'b1 : ctr[i];
      item[XLEN + 32 + i*COUNTER_WIDTH +: COUNTER_WIDTH] = ctr_inc[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_EVENTS; i++) ctr[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_EVENTS; i++) ctr[i] <= push_ok ? '0 : ctr_inc[i];
    end
  end

  // NOTE: FIFO storage is not reset; pointers and count define validity and tdata is gated by tvalid.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wr_ptr] <= item;
  end

  always_comb begin
    if (flush) count_next = '0;
    else       count_next = count + CNT_W'(push_ok) - CNT_W'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      count <= count_next;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        wr_ptr <= wr_ptr + PTR_W'(push_ok);
        rd_ptr <= rd_ptr + PTR_W'(pop);
      end
    end
  end

  assign M_AXIS_tvalid = (count != '0);
  assign M_AXIS_tdata  = M_AXIS_tvalid ? AXI_DATA_WIDTH'(mem[rd_ptr]) : '0;
  assign last_idx      = (tlast_interval <= 32'd1) ? 32'd0 : tlast_interval - 32'd1;
  // >= rather than == so a shrunken interval closes the packet on the very next beat.
  assign M_AXIS_tlast  = M_AXIS_tvalid & ((drain & (count == CNT_W'(1))) | (beat_cnt >= last_idx));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt   <= '0;
      drain      <= 1'b0;
      drop_count <= '0;
    end else begin
      if (flush)    beat_cnt <= '0;
      else if (pop) beat_cnt <= M_AXIS_tlast ? 32'd0 : beat_cnt + 32'd1;

      if (flush)                                      drain <= 1'b0;
      else if (en_q && !en)                           drain <= (count_next != '0);
      else if (pop && drain && count == CNT_W'(1))    drain <= 1'b0;

      if (flush)                       drop_count <= '0;
      else if (drop && drop_count != '1) drop_count <= drop_count + 32'd1;
    end
  end
endmodule

// File: tb/tb_cms_trace_packer.sv
// Randomised bench for cms_trace_packer against a queue-based transaction model of the trace stream.
module tb_cms_trace_packer;
  localparam int XLEN   = 64;
  localparam int NE     = 8;
  localparam int CW     = 16;
  localparam int AW     = 512;
  localparam int DEPTH  = 16;
  localparam int ITEM_W = XLEN + 32 + NE * CW;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [31:0]     instr = '0;
  logic [XLEN-1:0] pc = '0;
  logic            pc_valid = 1'b0;
  logic [NE-1:0]   performance_events = '0;
  logic            en = 1'b1;
  logic [7:0]      ctrl_addr = '0;
  logic [63:0]     ctrl_wdata = '0;
  logic            ctrl_write_enable = 1'b0;
  logic [31:0]     tlast_interval = 32'd4;
  logic            M_AXIS_tvalid, M_AXIS_tready, M_AXIS_tlast;
  logic [AW-1:0]   M_AXIS_tdata;
  logic [31:0]     drop_count;

  cms_trace_packer dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .pc(pc), .pc_valid(pc_valid),
    .performance_events(performance_events), .en(en), .ctrl_addr(ctrl_addr),
    .ctrl_wdata(ctrl_wdata), .ctrl_write_enable(ctrl_write_enable),
    .tlast_interval(tlast_interval), .M_AXIS_tvalid(M_AXIS_tvalid),
    .M_AXIS_tready(M_AXIS_tready), .M_AXIS_tdata(M_AXIS_tdata),
    .M_AXIS_tlast(M_AXIS_tlast), .drop_count(drop_count)
  );

  always #5 clk = ~clk;
  initial M_AXIS_tready = 1'b1;

  int vectors = 0;
  int miscompares = 0;

  // Transaction model state.
  logic [ITEM_W-1:0] q[$];
  int unsigned       m_ctr[NE];
  int unsigned       m_drops, m_beats;
  bit                m_drain, m_prev_en, m_prev_we, m_trace_en, m_filter_en;
  logic [XLEN-1:0]   m_lo, m_hi;

  // Beats actually accepted on the DUT port.
  logic [AW-1:0]     log_data[$];
  bit                log_last[$];

  task automatic model_reset();
    q.delete();
    for (int i = 0; i < NE; i++) m_ctr[i] = 0;
    m_drops = 0; m_beats = 0; m_drain = 0; m_prev_en = 0; m_prev_we = 0;
    m_trace_en = 0; m_filter_en = 0; m_lo = '0; m_hi = '1;
  endtask

  function automatic bit exp_tlast();
    int unsigned idx;
    idx = (tlast_interval <= 1) ? 0 : tlast_interval - 1;
    return q.size() != 0 && ((m_drain && q.size() == 1) || m_beats >= idx);
  endfunction

  // One clock: compare DUT outputs with the model at negedge, then advance the model over the edge.
  task automatic tick();
    bit wr, pop, cap, et;
    logic [ITEM_W-1:0] it;
    @(negedge clk);
    et = exp_tlast();
    vectors++;
    if (M_AXIS_tvalid !== (q.size() != 0)) begin
      miscompares++; $display("FAIL tvalid: got %b want %b", M_AXIS_tvalid, q.size() != 0);
    end
    vectors++;
    if (M_AXIS_tlast !== et) begin
      miscompares++; $display("FAIL tlast: got %b want %b", M_AXIS_tlast, et);
    end
    vectors++;
    if (M_AXIS_tdata !== ((q.size() != 0) ? AW'(q[0]) : '0)) begin
      miscompares++;
      $display("FAIL tdata: got %h want %h", M_AXIS_tdata, (q.size() != 0) ? AW'(q[0]) : '0);
    end
    vectors++;
    if (drop_count !== m_drops) begin
      miscompares++; $display("FAIL drop_count: got %0d want %0d", drop_count, m_drops);
    end
    if (M_AXIS_tvalid && M_AXIS_tready) begin
      log_data.push_back(M_AXIS_tdata);
      log_last.push_back(M_AXIS_tlast);
    end
    if (rst_n) begin
      wr = ctrl_write_enable && !m_prev_we;
      m_prev_we = ctrl_write_enable;
      pop = q.size() != 0 && M_AXIS_tready;
      if (pop) begin
        m_beats = et ? 0 : m_beats + 1;
        if (m_drain && q.size() == 1) m_drain = 0;
        void'(q.pop_front());
      end
      cap = en && m_trace_en && pc_valid && (!m_filter_en || (pc >= m_lo && pc <= m_hi));
      for (int i = 0; i < NE; i++)
        if (performance_events[i] && m_ctr[i] != 32'hFFFF) m_ctr[i]++;
      if (cap) begin
        if (q.size() < DEPTH) begin
          it = '0; it[XLEN-1:0] = pc; it[XLEN +: 32] = instr;
          for (int i = 0; i < NE; i++) it[XLEN + 32 + i*CW +: CW] = m_ctr[i][CW-1:0];
          q.push_back(it);
          for (int i = 0; i < NE; i++) m_ctr[i] = 0;
        end else if (m_drops != 32'hFFFF_FFFF) m_drops++;
      end
      if (m_prev_en && !en) m_drain = (q.size() != 0);
      m_prev_en = en;
      if (wr) begin
        case (ctrl_addr)
          8'h00: begin m_trace_en = ctrl_wdata[0]; m_filter_en = ctrl_wdata[1]; end
          8'h01: m_lo = ctrl_wdata;
          8'h02: m_hi = ctrl_wdata;
          8'h03: begin q.delete(); m_drops = 0; m_beats = 0; m_drain = 0; end
          default: ;
        endcase
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    pc_valid = 0; performance_events = '0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic ctrl_write(input logic [7:0] a, input logic [63:0] d);
    ctrl_addr = a; ctrl_wdata = d; ctrl_write_enable = 1; tick();
    ctrl_write_enable = 0; tick();
  endtask

  task automatic retire(input logic [XLEN-1:0] p);
    pc = p; instr = $urandom; pc_valid = 1; tick(); pc_valid = 0;
  endtask

  task automatic test_reset();
    rst_n = 0; model_reset();
    #1;
    vectors++;
    if ({M_AXIS_tvalid, M_AXIS_tlast} !== 2'b00 || M_AXIS_tdata !== '0 || drop_count !== 0) begin
      miscompares++;
      $display("FAIL reset_state: got v=%b l=%b d=%h drops=%0d want all zero",
               M_AXIS_tvalid, M_AXIS_tlast, M_AXIS_tdata, drop_count);
    end
    idle(3);
    rst_n = 1;
    idle(2);
  endtask

  task automatic test_back_to_back();
    tlast_interval = 4; M_AXIS_tready = 1;
    ctrl_write(8'h00, 64'h1);
    log_data.delete(); log_last.delete();
    for (int i = 0; i < 10; i++) begin
      pc = 64'h100 + 64'(4*i); instr = $urandom; pc_valid = 1; tick();
    end
    idle(4);
    vectors++;
    if (log_data.size() != 10) begin
      miscompares++; $display("FAIL b2b_beats: got %0d want 10", log_data.size());
    end else begin
      for (int i = 0; i < 10; i++) begin
        vectors++;
        if (log_last[i] !== (i == 3 || i == 7) || log_data[i][XLEN-1:0] !== 64'h100 + 64'(4*i)) begin
          miscompares++;
          $display("FAIL b2b_beat%0d: got last=%b pc=%h want last=%b pc=%h", i, log_last[i],
                   log_data[i][XLEN-1:0], (i == 3 || i == 7), 64'h100 + 64'(4*i));
        end
      end
    end
  endtask

  task automatic test_event_count();
    logic [CW-1:0] got;
    M_AXIS_tready = 1;
    retire(64'h2000);
    performance_events = 8'h01;
    for (int i = 0; i < 4; i++) tick();
    pc = 64'h2004; instr = $urandom; pc_valid = 1; tick(); pc_valid = 0;
    idle(3);
    got = log_data[log_data.size()-1][XLEN + 32 +: CW];
    vectors++;
    if (got !== 16'd5) begin
      miscompares++; $display("FAIL ctr0_delta: got %0d want 5", got);
    end
    performance_events = 8'h01;
    for (int i = 0; i < 65600; i++) tick();
    pc = 64'h2008; instr = $urandom; pc_valid = 1; tick(); pc_valid = 0;
    idle(3);
    got = log_data[log_data.size()-1][XLEN + 32 +: CW];
    vectors++;
    if (got !== 16'hFFFF) begin
      miscompares++; $display("FAIL ctr0_saturate: got %h want ffff", got);
    end
  endtask

  task automatic test_filter();
    logic [XLEN-1:0] pcs[4];
    pcs = '{64'h0FFC, 64'h1000, 64'h1FFF, 64'h2000};
    ctrl_write(8'h01, 64'h1000);
    ctrl_write(8'h02, 64'h1FFF);
    ctrl_write(8'h00, 64'h3);
    log_data.delete(); log_last.delete();
    for (int i = 0; i < 4; i++) begin retire(pcs[i]); tick(); end
    idle(3);
    vectors++;
    if (log_data.size() != 2 || log_data[0][XLEN-1:0] !== 64'h1000 || log_data[1][XLEN-1:0] !== 64'h1FFF) begin
      miscompares++;
      $display("FAIL filter: got %0d beats first=%h want 2 beats 1000,1fff", log_data.size(),
               (log_data.size() != 0) ? log_data[0][XLEN-1:0] : 64'h0);
    end
    ctrl_write(8'h00, 64'h1);
  endtask

  task automatic test_overflow();
    logic [AW-1:0] held;
    M_AXIS_tready = 0;
    for (int i = 0; i < 20; i++) begin
      pc = 64'h3000 + 64'(i); instr = $urandom; pc_valid = 1; tick();
    end
    idle(2);
    held = M_AXIS_tdata;
    idle(3);
    vectors++;
    if (drop_count !== 32'd4 || M_AXIS_tdata !== held || held[XLEN-1:0] !== 64'h3000) begin
      miscompares++;
      $display("FAIL overflow: got drops=%0d head pc=%h want drops=4 head pc=3000 stable",
               drop_count, M_AXIS_tdata[XLEN-1:0]);
    end
    ctrl_write(8'h03, 64'h0);
    vectors++;
    if (M_AXIS_tvalid !== 1'b0 || drop_count !== 0) begin
      miscompares++; $display("FAIL flush: got v=%b drops=%0d want 0 0", M_AXIS_tvalid, drop_count);
    end
    M_AXIS_tready = 1;
  endtask

  task automatic test_drain();
    ctrl_write(8'h03, 64'h0);
    tlast_interval = 4; M_AXIS_tready = 0;
    for (int i = 0; i < 6; i++) retire(64'h4000 + 64'(4*i));
    idle(2);
    log_data.delete(); log_last.delete();
    en = 0; tick();
    M_AXIS_tready = 1;
    idle(10);
    vectors++;
    if (log_last.size() != 6) begin
      miscompares++; $display("FAIL drain_beats: got %0d want 6", log_last.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        vectors++;
        if (log_last[i] !== (i == 3 || i == 5)) begin
          miscompares++; $display("FAIL drain_tlast%0d: got %b want %b", i, log_last[i], (i == 3 || i == 5));
        end
      end
    end
    vectors++;
    if (dut.drain !== 1'b0) begin
      miscompares++; $display("FAIL drain_flag: got %b want 0", dut.drain);
    end
    en = 1; idle(2);
  endtask

  task automatic test_reset_mid();
    M_AXIS_tready = 0;
    for (int i = 0; i < 20; i++) retire(64'h5000 + 64'(i));
    #2 rst_n = 0;
    #1;
    vectors++;
    if (M_AXIS_tvalid !== 1'b0 || drop_count !== 0 || M_AXIS_tdata !== '0) begin
      miscompares++;
      $display("FAIL async_reset: got v=%b drops=%0d want 0 0", M_AXIS_tvalid, drop_count);
    end
    model_reset();
    idle(2);
    rst_n = 1;
    idle(1);
    M_AXIS_tready = 1;
    ctrl_write(8'h00, 64'h1);
    log_data.delete(); log_last.delete();
    retire(64'h6000);
    idle(3);
    vectors++;
    if (log_data.size() != 1 || log_data[0][XLEN-1:0] !== 64'h6000) begin
      miscompares++; $display("FAIL post_reset_item: got %0d beats want 1 with pc 6000", log_data.size());
    end
  endtask

  task automatic test_random();
    ctrl_write(8'h01, 64'h1000);
    ctrl_write(8'h02, 64'h2FFF);
    ctrl_write(8'h00, 64'h3);
    for (int i = 0; i < 3000; i++) begin
      pc = 64'($urandom_range(0, 16'h3FFF));
      instr = $urandom;
      pc_valid = ($urandom_range(0, 3) != 0);
      performance_events = NE'($urandom);
      M_AXIS_tready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 99) == 0) en = ~en;
      if ($urandom_range(0, 199) == 0) tlast_interval = $urandom_range(0, 6);
      tick();
    end
    en = 1; pc_valid = 0; M_AXIS_tready = 1;
    idle(DEPTH + 4);
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_event_count();
    test_filter();
    test_overflow();
    test_drain();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
